// File: rtl/wb_fifo_device.sv
// rtl/wb_fifo_device.sv - Wishbone slave fronting a small FIFO with programmable wait states
module wb_fifo_device #(
    parameter int DAT_WIDTH   = 8,
    parameter int DEPTH       = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [DAT_WIDTH-1:0]     dat_i,
    output logic                     ack_o,
    output logic                     err_o,
    output logic                     rty_o,
    output logic [DAT_WIDTH-1:0]     dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state_q,  state_d;
    logic [3:0]             wcnt_q,   wcnt_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q,  count_d;
    logic                   full_q,   full_d;
    logic                   empty_q,  empty_d;
    logic                   ack_q,    ack_d;
    logic                   rty_q,    rty_d;
    logic [DAT_WIDTH-1:0]   dat_q,    dat_d;
    logic [DAT_WIDTH-1:0]   mem_q [DEPTH];

    logic req;
    logic commit;
    logic push;
    logic pop;

    assign req = cyc_i && stb_i;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dat_d    = dat_q;
        ack_d    = 1'b0;
        rty_d    = 1'b0;
        commit   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = WS_LOAD;
                    end else begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Dropping cyc_i abandons the cycle before anything commits.
                if (!cyc_i) begin
                    state_d = S_IDLE;
                    wcnt_d  = 4'd0;
                end else if (wcnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                wcnt_d  = 4'd0;
            end
        endcase

        if (commit) begin
            if (we_i) begin
                if (!full_q) begin
                    push  = 1'b1;
                    ack_d = 1'b1;
                end else begin
                    rty_d = 1'b1;
                end
            end else begin
                if (!empty_q) begin
                    pop   = 1'b1;
                    dat_d = mem_q[rd_ptr_q];
                    ack_d = 1'b1;
                end else begin
                    rty_d = 1'b1;
                end
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end

        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ack_q    <= 1'b0;
            rty_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ack_q    <= ack_d;
            rty_q    <= rty_d;
            dat_q    <= dat_d;
        end
    end

    // Storage is not reset; a reset only rewinds the pointers.
    always_ff @(posedge clk_i) begin
        if (push && rst_ni) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    assign ack_o   = ack_q;
    assign rty_o   = rty_q;
    assign err_o   = 1'b0;
    assign dat_o   = dat_q;
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: tb/tb_wb_fifo_device.sv
// tb/tb_wb_fifo_device.sv - self-checking bench for wb_fifo_device (WAIT_STATES 0 and 3)
module tb_wb_fifo_device;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      cyc, stb, we, ack, err, rty, full, empty;
    logic [1:0][7:0] din, dout;
    logic [1:0][2:0] cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int         dut;
        logic       ack;
        logic       rty;
        logic [7:0] dat;
        logic [2:0] cnt;
    } exp_t;

    typedef struct {
        logic       we;
        logic [7:0] dat;
        logic       ack;
        logic       rty;
        logic [7:0] edat;
        logic [2:0] ecnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    wb_fifo_device #(.DAT_WIDTH(8), .DEPTH(4), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .dat_i(din[0]), .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0]), .dat_o(dout[0]),
        .count_o(cnt[0]), .full_o(full[0]), .empty_o(empty[0])
    );

    wb_fifo_device #(.DAT_WIDTH(8), .DEPTH(4), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .dat_i(din[1]), .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1]), .dat_o(dout[1]),
        .count_o(cnt[1]), .full_o(full[1]), .empty_o(empty[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input int d);
        chk("rst_ack",   32'(ack[d]),   0);
        chk("rst_rty",   32'(rty[d]),   0);
        chk("rst_err",   32'(err[d]),   0);
        chk("rst_dat",   32'(dout[d]),  0);
        chk("rst_count", 32'(cnt[d]),   0);
        chk("rst_full",  32'(full[d]),  0);
        chk("rst_empty", 32'(empty[d]), 1);
    endtask

    // Scoreboard: every response pops one expectation pushed when the request was driven.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("err_const", 32'(err[d]), 0);
            if (ack[d] || rty[d]) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resp: dut %0d ack %0b rty %0b required none", d, ack[d], rty[d]);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_dut", 32'(d),        32'(mon_e.dut));
                    chk("ack",      32'(ack[d]),   32'(mon_e.ack));
                    chk("rty",      32'(rty[d]),   32'(mon_e.rty));
                    chk("dat_o",    32'(dout[d]),  32'(mon_e.dat));
                    chk("count",    32'(cnt[d]),   32'(mon_e.cnt));
                    chk("full",     32'(full[d]),  32'(mon_e.cnt == 3'd4));
                    chk("empty",    32'(empty[d]), 32'(mon_e.cnt == 3'd0));
                end
            end
        end
    end

    task automatic txn(input int d, input logic w, input logic [7:0] v, input logic eack,
                       input logic erty, input logic [7:0] edat, input logic [2:0] ecnt, input int ws);
        exp_t e;
        int   n;
        e.dut = d; e.ack = eack; e.rty = erty; e.dat = edat; e.cnt = ecnt;
        sb.push_back(e);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; din[d] = v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack[d] || rty[d]) && n < 40);
        if (!(ack[d] || rty[d])) begin
            n_cmp++;
            n_fail++;
            $display("FAIL resp_timeout: dut %0d no response after %0d cycles, required %0d", d, n, ws + 1);
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end else begin
            chk("latency", 32'(n), 32'(ws + 1));
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", 32'({ack[d], rty[d]}), 0);
    endtask

    initial begin
        logic [7:0] last;
        cyc = '0; stb = '0; we = '0; din = '0; rst_n = 1'b0;

        vecs.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 3'd0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd0});
        vecs.push_back('{1'b1, 8'h11, 1'b1, 1'b0, 8'hA5, 3'd1});
        vecs.push_back('{1'b1, 8'h22, 1'b1, 1'b0, 8'hA5, 3'd2});
        vecs.push_back('{1'b1, 8'h33, 1'b1, 1'b0, 8'hA5, 3'd3});
        vecs.push_back('{1'b1, 8'h44, 1'b1, 1'b0, 8'hA5, 3'd4});
        vecs.push_back('{1'b1, 8'h55, 1'b0, 1'b1, 8'hA5, 3'd4});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 3'd3});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 3'd2});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 3'd1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 3'd0});
        last = 8'h44;
        for (int k = 1; k <= 6; k++) begin
            vecs.push_back('{1'b1, 8'(k), 1'b1, 1'b0, last, 3'd1});
            vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'(k), 3'd0});
            last = 8'(k);
        end

        repeat (2) @(negedge clk);
        #2;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            txn(0, vecs[i].we, vecs[i].dat, vecs[i].ack, vecs[i].rty, vecs[i].edat, vecs[i].ecnt, 0);

        // cyc without stb must be ignored
        cyc[0] = 1'b1; stb[0] = 1'b0; we[0] = 1'b1; din[0] = 8'hEE;
        repeat (3) @(negedge clk);
        chk("stb_low_count", 32'(cnt[0]), 0);
        chk("stb_low_empty", 32'(empty[0]), 1);
        cyc[0] = 1'b0;
        @(negedge clk);

        txn(1, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 3'd1, 3);

        // abort: cyc drops two edges into the wait period
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; din[1] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_resp", 32'({ack[1], rty[1]}), 0);
        end
        chk("abort_count", 32'(cnt[1]), 1);
        txn(1, 1'b1, 8'h6B, 1'b1, 1'b0, 8'h00, 3'd2, 3);

        // reset in the middle of a waited write with two entries held
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; din[1] = 8'h7C;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset(1);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk);
        chk_reset(1);
        rst_n = 1'b1;
        txn(1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 3);

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries remaining, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/wb_fifo_device.md
WB_FIFO_DEVICE -- requirements
Module: wb_fifo_device

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 8: data width of the bus and FIFO.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter WAIT_STATES, default 0: extra cycles inserted before each response; range 0..15.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk_i  input  1  rising-edge clock.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 cyc_i  input  1  Wishbone cycle valid.
REQ-008 stb_i  input  1  Wishbone strobe.
REQ-009 we_i  input  1  1 = write (push), 0 = read (pop).
REQ-010 dat_i  input  DAT_WIDTH  write data from the controller.
REQ-011 ack_o  output  1  normal termination.
REQ-012 err_o  output  1  error termination; reserved, tied to 0.
REQ-013 rty_o  output  1  retry termination: write while full, or read while empty.
REQ-014 dat_o  output  DAT_WIDTH  read data, valid while ack_o is high on a read.
REQ-015 count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 full_o  output  1  count_o == DEPTH.
REQ-017 empty_o  output  1  count_o == 0.

Function
REQ-018 SHALL implement a three-state FSM:
- IDLE: waiting for a request.
- WAIT: inserting wait states.
- RESP: driving the response.
REQ-019 SHALL define a request as cyc_i && stb_i.
REQ-020 IDLE SHALL transition as follows when a request is present:
- to WAIT if WAIT_STATES > 0, with the wait counter loaded to WAIT_STATES-1;
- otherwise to RESP.
REQ-021 WAIT SHALL transition as follows:
- to IDLE if cyc_i drops (abort), with no FIFO change;
- to RESP on the clock edge where the wait counter is 0;
- otherwise decrement the counter.
REQ-022 RESP SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-023 Response latency (ack_o or rty_o registered, never combinational) SHALL be:
- request first seen high in IDLE at edge T -> response high in cycle T+1+WAIT_STATES.
REQ-024 Operations SHALL commit on the edge entering RESP, using we_i and dat_i sampled at that edge.
REQ-025 A write SHALL commit as follows:
- not full: push dat_i at the write pointer, increment count, assert ack_o in RESP;
- full: no push, assert rty_o.
REQ-026 A read SHALL commit as follows:
- not empty: load dat_o with the head entry, pop, decrement count, assert ack_o;
- empty: no pop, assert rty_o, dat_o unchanged.
REQ-027 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-028 A single transaction SHALL never push and pop simultaneously.
REQ-029 dat_o SHALL hold its last loaded value between reads.
REQ-030 ack_o and rty_o SHALL be mutually exclusive and high only in RESP.
REQ-031 err_o SHALL be constant 0.
REQ-032 A controller holding its request asserted through RESP SHALL see its next cycle start in IDLE on the following edge: one idle cycle between back-to-back transactions.
REQ-033 count_o, full_o and empty_o SHALL be registered and reflect the committed state.
REQ-034 A request with cyc_i high and stb_i low SHALL have no effect.

Reset
REQ-035 When rst_ni is low, SHALL asynchronously force:
- FSM to IDLE and wait counter to 0;
- both pointers and count_o to 0;
- ack_o, rty_o, err_o to 0 and dat_o to 0;
- empty_o to 1 and full_o to 0.
REQ-036 Reset asserted mid-transaction (WAIT or RESP) SHALL abandon the transaction with no commit; FIFO contents are not cleared but are unreachable.
REQ-037 The first request SHALL be accepted at the first rising edge after rst_ni deasserts.

Verification
REQ-038 WAIT_STATES=0, DEPTH=4: write 0xA5 -> ack_o high 1 cycle later for exactly 1 cycle; count_o=1; empty_o=0.
REQ-039 DEPTH=4, push 0x11,0x22,0x33,0x44, then a 5th write 0x55 -> rty_o pulse, count_o stays 4, full_o=1; four reads return 0x11,0x22,0x33,0x44.
REQ-040 Empty FIFO, read -> rty_o pulse, ack_o=0, dat_o unchanged, count_o=0.
REQ-041 DEPTH=4: 6 write/read pairs of 0x01..0x06 -> each read returns the matching value; verifies pointer wrap.
REQ-042 WAIT_STATES=3: write request at edge T -> ack_o in cycle T+4; a second run dropping cyc_i at T+2 -> no ack, count_o unchanged, FSM back in IDLE.
REQ-043 rst_ni pulsed low while in WAIT with 2 entries stored -> all outputs at reset values immediately; count_o=0; next read gets rty_o.
